// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
// Geometry is derived from LINES and LINE_WORDS; DEF_* give the default build.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        FILL_DONE = 2'd2
    } icache_state_e;

    localparam logic [31:0] NOP_INSTR = 32'hFC000000;

    localparam int DEF_LINES      = 16;
    localparam int DEF_LINE_WORDS = 4;

    function automatic int word_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Byte offset (2 bits) + word select + index; the tag is everything above.
    function automatic int tag_w(input int lines, input int line_words);
        return 32 - 2 - $clog2(line_words) - $clog2(lines);
    endfunction

    localparam int DEF_INDEX_W = index_w(DEF_LINES);
    localparam int DEF_TAG_W   = tag_w(DEF_LINES, DEF_LINE_WORDS);

endpackage

// File: rtl/icache_data_array.sv
// Instruction data storage: LINES x LINE_WORDS x 32, asynchronous read port,
// synchronous single-word write port used by the refill engine. No reset.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                           clk_i,
    input  logic                           we_i,
    input  logic [index_w(LINES)-1:0]      widx_i,
    input  logic [word_w(LINE_WORDS)-1:0]  wword_i,
    input  logic [31:0]                    wdata_i,
    input  logic [index_w(LINES)-1:0]      ridx_i,
    input  logic [word_w(LINE_WORDS)-1:0]  rword_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [LINES][LINE_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_i][wword_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i][rword_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, line refill on miss.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module instr_cache
    import icache_pkg::*;
#(
    parameter int LINES      = DEF_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        iMemError,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WW  = word_w(LINE_WORDS);
    localparam int IW  = index_w(LINES);
    localparam int TW  = tag_w(LINES, LINE_WORDS);
    localparam int OFF = 2 + WW;
    localparam int BW  = 32 - OFF;
    localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);

    icache_state_e   state_q;
    logic [LINES-1:0] valid_q;
    logic [TW-1:0]   tag_q [LINES];
    logic [BW-1:0]   refill_base_q;
    logic [WW-1:0]   wcnt_q;
    logic            mem_req_q;

    logic [IW-1:0]   pc_index;
    logic [IW-1:0]   fill_index;
    logic [TW-1:0]   pc_tag;
    logic [TW-1:0]   fill_tag;
    logic [WW-1:0]   pc_word;
    logic            hit;
    logic            idle_hit;
    logic            fill_we;
    logic            fill_last;
    logic [31:0]     rdata;
    logic [1:0]      unused_pc_lsb;

    assign unused_pc_lsb = PC[1:0];

    assign pc_word    = PC[2 +: WW];
    assign pc_index   = PC[OFF +: IW];
    assign pc_tag     = PC[31 -: TW];
    // refill_base_q holds only the line-address bits; the byte offset is always zero.
    assign fill_index = refill_base_q[0 +: IW];
    assign fill_tag   = refill_base_q[BW-1 -: TW];

    assign hit       = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign idle_hit  = (state_q == IDLE) && hit;
    assign fill_we   = (state_q == REFILL) && mem_ack;
    assign fill_last = fill_we && (wcnt_q == LAST_WORD);

    assign Instruction = idle_hit ? rdata : NOP_INSTR;
    assign iMemError   = !idle_hit;
    assign mem_req     = mem_req_q;
    assign mem_addr    = {refill_base_q, wcnt_q, 2'b00};

    icache_data_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_data (
        .clk_i   (Clk),
        .we_i    (fill_we),
        .widx_i  (fill_index),
        .wword_i (wcnt_q),
        .wdata_i (mem_rdata),
        .ridx_i  (pc_index),
        .rword_i (pc_word),
        .rdata_o (rdata)
    );

    always_ff @(posedge Clk) begin
        if (fill_last) begin
            tag_q[fill_index] <= fill_tag;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            wcnt_q        <= '0;
            refill_base_q <= '0;
            mem_req_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        state_q       <= REFILL;
                        refill_base_q <= PC[31:OFF];
                        wcnt_q        <= '0;
                        mem_req_q     <= 1'b1;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        wcnt_q <= wcnt_q + 1'b1;
                        if (wcnt_q == LAST_WORD) begin
                            valid_q[fill_index] <= 1'b1;
                            state_q             <= FILL_DONE;
                            mem_req_q           <= 1'b0;
                        end
                    end
                end
                FILL_DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == IDLE) begin
            if (hit && (hit_count != 32'hFFFFFFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (!hit && (miss_count != 32'hFFFFFFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
